// File: rtl/mau_pkg.sv
// mau_pkg: default widths shared along the memory-access path
package mau_pkg;
  localparam int INSTRUCTION_LENGTH = 32;
  localparam int OPCODE_LENGTH = 7;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/mau_sync_fifo.sv
// mau_sync_fifo: single-clock FIFO with extra-MSB pointers, cleared storage on reset
module mau_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  always_comb begin
    full_o = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty_o = wr_ptr == rd_ptr;
    level_o = wr_ptr - rd_ptr;
    head_o = mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem[wr_ptr[AW-1:0]] <= data_i;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop_i && !empty_o) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/mau_issue_queue.sv
// mau_issue_queue: buffers memory-access instructions and issues one at a time
// to MemoryAccessUnit, tracking the outstanding op and debug counters.
module mau_issue_queue #(
  parameter int INSTRUCTION_LENGTH = mau_pkg::INSTRUCTION_LENGTH,
  parameter int QUEUE_DEPTH = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [INSTRUCTION_LENGTH-1:0]   instruction_i,
  input  logic                            instruction_valid_i,
  output logic                            instruction_ready_o,
  output logic [INSTRUCTION_LENGTH-1:0]   issue_instruction_o,
  output logic                            issue_valid_o,
  input  logic                            issue_ready_i,
  input  logic                            issue_done_i,
  output logic [$clog2(QUEUE_DEPTH):0]    fill_level_o,
  output logic                            busy_o,
  output logic [COUNT_WIDTH-1:0]          issued_count_o,
  output logic [COUNT_WIDTH-1:0]          completed_count_o,
  output logic                            spurious_done_o
);
  logic full, empty, outstanding, issue;
  mau_sync_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(INSTRUCTION_LENGTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (instruction_valid_i),
    .data_i  (instruction_i),
    .pop_i   (issue),
    .head_o  (issue_instruction_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fill_level_o)
  );
  always_comb begin
    instruction_ready_o = !full;
    issue_valid_o = !empty && !outstanding;
    issue = issue_valid_o && issue_ready_i;
    busy_o = !empty || outstanding;
  end
  // a done with nothing in flight only flags; issue may still set outstanding on that edge
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      outstanding <= 1'b0;
      issued_count_o <= '0;
      completed_count_o <= '0;
      spurious_done_o <= 1'b0;
    end else begin
      if (issue_done_i && outstanding) begin
        outstanding <= 1'b0;
        completed_count_o <= completed_count_o + COUNT_WIDTH'(1);
      end
      if (issue_done_i && !outstanding) spurious_done_o <= 1'b1;
      if (issue) begin
        outstanding <= 1'b1;
        issued_count_o <= issued_count_o + COUNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_mau_issue_queue.sv
// tb_mau_issue_queue: directed and random traffic checked against a queue-based model
module tb_mau_issue_queue;
  logic clk_i = 0, reset_i = 0;
  logic [31:0] instruction_i = 0, issue_instruction_o;
  logic instruction_valid_i = 0, instruction_ready_o, issue_valid_o;
  logic issue_ready_i = 0, issue_done_i = 0, busy_o, spurious_done_o;
  logic [2:0] fill_level_o;
  logic [3:0] issued_count_o, completed_count_o;
  int checks = 0, failures = 0;
  logic [31:0] q[$];
  logic [31:0] seen[$];
  bit out_m, spur_m;
  int issued_m, completed_m;

  mau_issue_queue #(.INSTRUCTION_LENGTH(32), .QUEUE_DEPTH(4), .COUNT_WIDTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .instruction_i(instruction_i),
    .instruction_valid_i(instruction_valid_i), .instruction_ready_o(instruction_ready_o),
    .issue_instruction_o(issue_instruction_o), .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i), .issue_done_i(issue_done_i), .fill_level_o(fill_level_o),
    .busy_o(busy_o), .issued_count_o(issued_count_o), .completed_count_o(completed_count_o),
    .spurious_done_o(spurious_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    out_m = 0; spur_m = 0; issued_m = 0; completed_m = 0;
  endtask

  task automatic check_state();
    chk("ready", instruction_ready_o, q.size() < 4);
    chk("valid", issue_valid_o, q.size() > 0 && !out_m);
    if (q.size() > 0 && !out_m) chk("head", issue_instruction_o, q[0]);
    chk("fill", fill_level_o, q.size());
    chk("busy", busy_o, q.size() > 0 || out_m);
    chk("issued", issued_count_o, issued_m % 16);
    chk("completed", completed_count_o, completed_m % 16);
    chk("spurious", spurious_done_o, spur_m);
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit r, input bit dn);
    bit push, iss;
    instruction_valid_i = v; instruction_i = d; issue_ready_i = r; issue_done_i = dn;
    #1;
    check_state();
    push = v && q.size() < 4;
    iss = q.size() > 0 && !out_m && r;
    @(posedge clk_i); #1;
    if (dn) begin
      if (out_m) begin out_m = 0; completed_m++; end
      else spur_m = 1;
    end
    if (iss) begin seen.push_back(q.pop_front()); out_m = 1; issued_m++; end
    if (push) q.push_back(d);
    instruction_valid_i = 0; issue_ready_i = 0; issue_done_i = 0;
  endtask

  task automatic do_reset();
    reset_i = 1; #1;
    model_reset();
    check_state();
    chk("rst_head", issue_instruction_o, 0);
    @(posedge clk_i); #1;
    reset_i = 0;
    seen.delete();
  endtask

  initial begin
    do_reset();
    // single op, done three cycles after issue
    step(1, 32'hA5000001, 1, 0);
    step(0, 0, 1, 0);
    chk("single_issued", issued_count_o, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("single_completed", completed_count_o, 1);
    chk("single_busy", busy_o, 0);
    // fill with downstream stalled; fifth push dropped
    for (int i = 0; i < 5; i++) step(1, 32'h1000 + i, 0, 0);
    chk("fill_level", fill_level_o, 4);
    chk("fill_ready", instruction_ready_o, 0);
    // full + issue on same edge: push still blocked
    step(1, 32'hDEAD, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);
    end
    step(0, 0, 1, 1);
    chk("drain_fill", fill_level_o, 0);
    for (int i = 0; i < 4; i++) chk("drain_order", seen[i + 1], 32'h1000 + i);
    // back-to-back with single-cycle latency downstream
    for (int i = 0; i < 30; i++) step(1, $urandom, 1, out_m);
    for (int i = 0; i < 12; i++) step(0, 0, 1, out_m);
    // random traffic, then reset mid-traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0,
           out_m ? $urandom_range(0, 2) == 0 : $urandom_range(0, 40) == 0);
    step(1, 32'h55, 1, 0);
    do_reset();
    // done after reset is spurious
    step(0, 0, 0, 1);
    chk("spur_flag", spurious_done_o, 1);
    chk("spur_completed", completed_count_o, 0);
    // counter wrap at 4 bits
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1, i, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
    end
    chk("wrap_issued", issued_count_o, 1);
    chk("wrap_completed", completed_count_o, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
